// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, drives a single-outstanding imem
// request, and feeds the IF/ID register through a one-entry skid buffer.
module fetch_stage #(
    parameter logic [63:0] PC_RESET  = 64'h0,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [63:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    output logic        id_valid,
    output logic [63:0] id_pc,
    output logic [31:0] id_instr
);

    localparam int unsigned XLEN = 64;
    localparam int unsigned ILEN = 32;

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_FULL  = 2'd1,
        S_DRAIN = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [XLEN-1:0]   pc_q, pc_d;
    logic [XLEN-1:0]   drain_addr_q, drain_addr_d;
    logic              id_valid_q, id_valid_d;
    logic [XLEN-1:0]   id_pc_q, id_pc_d;
    logic [ILEN-1:0]   id_instr_q, id_instr_d;
    logic              buf_valid_q, buf_valid_d;
    logic [XLEN-1:0]   buf_pc_q, buf_pc_d;
    logic [ILEN-1:0]   buf_instr_q, buf_instr_d;

    logic              ack;
    logic              consumed;
    logic              id_free;
    logic [XLEN-1:0]   redirect_target;
    logic              unused_redirect_lsbs;

    // Request is a decode of the state register, forced low while in reset.
    assign imem_req  = ~reset & (state_q != S_FULL);
    assign imem_addr = (state_q == S_DRAIN) ? drain_addr_q : pc_q;

    assign ack             = imem_req & imem_ack;
    assign consumed        = id_valid_q & ~stall;
    assign id_free         = ~id_valid_q | ~stall;
    assign redirect_target = {redirect_pc[XLEN-1:2], 2'b00};
    assign unused_redirect_lsbs = ^redirect_pc[1:0];

    assign id_valid = id_valid_q;
    assign id_pc    = id_pc_q;
    assign id_instr = id_instr_q;

    // State, PC, IF/ID and skid-buffer registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_FETCH;
            pc_q         <= PC_RESET;
            drain_addr_q <= '0;
            id_valid_q   <= 1'b0;
            id_pc_q      <= '0;
            id_instr_q   <= NOP_INSTR;
            buf_valid_q  <= 1'b0;
            buf_pc_q     <= '0;
            buf_instr_q  <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            drain_addr_q <= drain_addr_d;
            id_valid_q   <= id_valid_d;
            id_pc_q      <= id_pc_d;
            id_instr_q   <= id_instr_d;
            buf_valid_q  <= buf_valid_d;
            buf_pc_q     <= buf_pc_d;
            buf_instr_q  <= buf_instr_d;
        end
    end

    // Next-state logic: redirect first, then capture/skid/drain handling.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        drain_addr_d = drain_addr_q;
        id_valid_d   = id_valid_q;
        id_pc_d      = id_pc_q;
        id_instr_d   = id_instr_q;
        buf_valid_d  = buf_valid_q;
        buf_pc_d     = buf_pc_q;
        buf_instr_d  = buf_instr_q;

        if (redirect_valid) begin
            id_valid_d  = 1'b0;
            buf_valid_d = 1'b0;
            pc_d        = redirect_target;
            unique case (state_q)
                S_FETCH: begin
                    // An unanswered request must be drained before reissuing.
                    if (!ack) begin
                        drain_addr_d = pc_q;
                        state_d      = S_DRAIN;
                    end
                end
                S_FULL:  state_d = S_FETCH;
                // A response arriving with the redirect closes the stale request.
                S_DRAIN: if (ack) state_d = S_FETCH;
                default: state_d = S_FETCH;
            endcase
        end else begin
            unique case (state_q)
                S_FETCH: begin
                    if (ack) begin
                        pc_d = pc_q + XLEN'(4);
                        if (id_free) begin
                            id_instr_d = imem_rdata;
                            id_pc_d    = pc_q;
                            id_valid_d = 1'b1;
                        end else begin
                            buf_instr_d = imem_rdata;
                            buf_pc_d    = pc_q;
                            buf_valid_d = 1'b1;
                            state_d     = S_FULL;
                        end
                    end else if (consumed) begin
                        id_valid_d = 1'b0;
                    end
                end
                S_FULL: begin
                    if (!stall) begin
                        id_instr_d  = buf_instr_q;
                        id_pc_d     = buf_pc_q;
                        id_valid_d  = 1'b1;
                        buf_valid_d = 1'b0;
                        state_d     = S_FETCH;
                    end
                end
                S_DRAIN: begin
                    if (ack) state_d = S_FETCH;
                end
                default: state_d = S_FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: scoreboard of expected {pc,instr} consumed
// from ID, plus per-cycle checks of the memory request side.
module tb_fetch_stage;

    logic        clk;
    logic        reset;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        stall;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        id_valid;
    logic [63:0] id_pc;
    logic [31:0] id_instr;

    logic        ack_en;
    logic [95:0] exp_q[$];
    int          n_vec;
    int          n_err;

    fetch_stage dut (
        .clk            (clk),
        .reset          (reset),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ack       (imem_ack),
        .imem_rdata     (imem_rdata),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .id_valid       (id_valid),
        .id_pc          (id_pc),
        .id_instr       (id_instr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction memory image: three known words, the rest tagged with the address.
    function automatic logic [31:0] mem_word(input logic [63:0] a);
        case (a)
            64'h0:   return 32'h0050_0093;
            64'h4:   return 32'h00A0_0113;
            64'h8:   return 32'h00F0_0193;
            default: return 32'h1000_0000 | {16'h0, a[15:0]};
        endcase
    endfunction

    assign imem_rdata = mem_word(imem_addr);
    assign imem_ack   = ack_en;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic push(input logic [63:0] pc, input logic [31:0] instr);
        exp_q.push_back({pc, instr});
    endtask

    // Apply inputs for this cycle, then move to the sampling point.
    task automatic drive(input logic a, input logic s, input logic rv, input logic [63:0] rpc);
        ack_en         = a;
        stall          = s;
        redirect_valid = rv;
        redirect_pc    = rpc;
        @(negedge clk);
    endtask

    task automatic nxt();
        @(posedge clk);
        #2;
    endtask

    // Monitor: every consumed ID entry must match the head of the scoreboard.
    always @(negedge clk) begin
        if (!reset && id_valid && !stall) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL id_out: got pc %h instr %h expected nothing", id_pc, id_instr);
            end else begin
                logic [95:0] e;
                e = exp_q.pop_front();
                if ({id_pc, id_instr} !== e) begin
                    n_err++;
                    $display("FAIL id_out: got pc %h instr %h expected pc %h instr %h",
                             id_pc, id_instr, e[95:32], e[31:0]);
                end
            end
        end
    end

    initial begin
        n_vec = 0;
        n_err = 0;
        reset = 1'b1;
        ack_en = 1'b0;
        stall = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = '0;

        // Reset values
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_req", 64'(imem_req), 64'd0);
        chk("rst_id_valid", 64'(id_valid), 64'd0);
        chk("rst_id_pc", id_pc, 64'd0);
        chk("rst_id_instr", 64'(id_instr), 64'h13);
        @(posedge clk); #2;
        reset = 1'b0;

        // Zero-wait fetch, then a 3-cycle stall filling the skid buffer
        push(64'h0, 32'h0050_0093);
        push(64'h4, 32'h00A0_0113);
        push(64'h8, 32'h00F0_0193);
        push(64'hC, 32'h1000_000C);
        drive(1, 0, 0, 0);
        chk("c0_req", 64'(imem_req), 64'd1);
        chk("c0_addr", imem_addr, 64'h0);
        chk("c0_valid", 64'(id_valid), 64'd0);
        nxt();
        drive(1, 0, 0, 0);
        chk("c1_addr", imem_addr, 64'h4);
        chk("c1_valid", 64'(id_valid), 64'd1);
        chk("c1_pc", id_pc, 64'h0);
        nxt();
        drive(1, 1, 0, 0);
        chk("c2_addr", imem_addr, 64'h8);
        chk("c2_pc", id_pc, 64'h4);
        nxt();
        drive(1, 1, 0, 0);
        chk("c3_req", 64'(imem_req), 64'd0);
        chk("c3_pc", id_pc, 64'h4);
        nxt();
        drive(1, 1, 0, 0);
        chk("c4_req", 64'(imem_req), 64'd0);
        nxt();
        drive(1, 0, 0, 0);
        chk("c5_req", 64'(imem_req), 64'd0);
        chk("c5_pc", id_pc, 64'h4);
        nxt();
        drive(1, 0, 0, 0);
        chk("c6_req", 64'(imem_req), 64'd1);
        chk("c6_addr", imem_addr, 64'hC);
        chk("c6_pc", id_pc, 64'h8);
        nxt();

        // Redirect to 0x100 coincident with the ack for 0x10
        push(64'h100, 32'h1000_0100);
        drive(1, 0, 1, 64'h100);
        chk("c7_addr", imem_addr, 64'h10);
        chk("c7_pc", id_pc, 64'hC);
        nxt();
        drive(1, 0, 0, 0);
        chk("c8_valid", 64'(id_valid), 64'd0);
        chk("c8_addr", imem_addr, 64'h100);
        nxt();

        // Redirect back to 0x8, then redirect to 0x203 while 0x8 waits 3 cycles
        drive(1, 0, 1, 64'h8);
        chk("c9_addr", imem_addr, 64'h104);
        chk("c9_pc", id_pc, 64'h100);
        nxt();
        drive(0, 0, 1, 64'h203);
        chk("c10_addr", imem_addr, 64'h8);
        chk("c10_valid", 64'(id_valid), 64'd0);
        nxt();
        for (int i = 0; i < 3; i++) begin
            drive((i == 2) ? 1'b1 : 1'b0, 0, 0, 0);
            chk("drain_req", 64'(imem_req), 64'd1);
            chk("drain_addr", imem_addr, 64'h8);
            chk("drain_valid", 64'(id_valid), 64'd0);
            nxt();
        end
        drive(1, 0, 0, 0);
        chk("c14_addr", imem_addr, 64'h200);
        chk("c14_valid", 64'(id_valid), 64'd0);
        nxt();

        // Fill FULL under stall, then redirect to 0x300 while still stalled
        drive(1, 1, 0, 0);
        chk("c15_addr", imem_addr, 64'h204);
        chk("c15_pc", id_pc, 64'h200);
        nxt();
        push(64'h300, 32'h1000_0300);
        drive(0, 1, 1, 64'h300);
        chk("c16_req", 64'(imem_req), 64'd0);
        chk("c16_pc", id_pc, 64'h200);
        nxt();
        drive(1, 0, 0, 0);
        chk("c17_valid", 64'(id_valid), 64'd0);
        chk("c17_req", 64'(imem_req), 64'd1);
        chk("c17_addr", imem_addr, 64'h300);
        nxt();

        // Enter DRAIN, then assert reset between edges
        drive(0, 0, 1, 64'h400);
        chk("c18_pc", id_pc, 64'h300);
        chk("c18_addr", imem_addr, 64'h304);
        nxt();
        drive(0, 0, 0, 0);
        chk("c19_addr", imem_addr, 64'h304);
        #1;
        reset = 1'b1;
        #1;
        chk("arst_req", 64'(imem_req), 64'd0);
        chk("arst_valid", 64'(id_valid), 64'd0);
        chk("arst_pc", id_pc, 64'd0);
        chk("arst_instr", 64'(id_instr), 64'h13);
        ack_en = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("hold_req", 64'(imem_req), 64'd0);
        chk("hold_valid", 64'(id_valid), 64'd0);
        chk("hold_addr", imem_addr, 64'h0);
        @(posedge clk); #2;
        reset = 1'b0;

        // Restart from PC_RESET, then wrap the PC past 2^64
        push(64'h0, 32'h0050_0093);
        push(64'h4, 32'h00A0_0113);
        push(64'h8, 32'h00F0_0193);
        push(64'hFFFF_FFFF_FFFF_FFFC, 32'h1000_FFFC);
        drive(1, 0, 0, 0);
        chk("r0_addr", imem_addr, 64'h0);
        chk("r0_valid", 64'(id_valid), 64'd0);
        nxt();
        drive(1, 0, 0, 0);
        chk("r1_addr", imem_addr, 64'h4);
        nxt();
        drive(1, 0, 0, 0);
        chk("r2_addr", imem_addr, 64'h8);
        nxt();
        drive(0, 0, 1, 64'hFFFF_FFFF_FFFF_FFFC);
        chk("r3_addr", imem_addr, 64'hC);
        chk("r3_pc", id_pc, 64'h8);
        nxt();
        drive(1, 0, 0, 0);
        chk("r4_addr", imem_addr, 64'hC);
        chk("r4_valid", 64'(id_valid), 64'd0);
        nxt();
        drive(1, 0, 0, 0);
        chk("r5_addr", imem_addr, 64'hFFFF_FFFF_FFFF_FFFC);
        nxt();
        drive(0, 0, 0, 0);
        chk("r6_wrap_addr", imem_addr, 64'h0);
        chk("r6_pc", id_pc, 64'hFFFF_FFFF_FFFF_FFFC);
        nxt();
        drive(0, 0, 0, 0);
        chk("r7_valid", 64'(id_valid), 64'd0);
        chk("r7_addr", imem_addr, 64'h0);
        nxt();

        chk("sb_empty", 64'(exp_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction fetch stage of the 64-bit RISC-V core.
- Owns the PC and drives a single-outstanding request/ack port to instruction memory.
- Delivers {instruction, pc} through the IF/ID register to the decoder and immediate generator.
- Provides stall handling via a one-entry skid buffer, and branch/jump redirect with flush.

Parameters:
- PC_RESET, 64'h0, PC value loaded on reset.
- NOP_INSTR, 32'h00000013, value of id_instr at reset (addi x0,x0,0).

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- imem_req  out  1  fetch request to instruction memory.
- imem_addr  out  64  fetch byte address; bits [1:0] always 0.
- imem_ack  in  1  memory response; sampled only while imem_req=1.
- imem_rdata  in  32  instruction word; valid in the imem_ack cycle.
- stall  in  1  decoder cannot accept; ID contents held.
- redirect_valid  in  1  taken branch/jump from EX.
- redirect_pc  in  64  redirect target; bits [1:0] ignored and treated as 0.
- id_valid  out  1  IF/ID register holds a live instruction.
- id_pc  out  64  PC of id_instr.
- id_instr  out  32  instruction to decode and immediate generation.

Behaviour:
- Reset (async, takes effect immediately):
  - pc=PC_RESET; state=FETCH.
  - imem_req=0 while reset is high.
  - id_valid=0, id_pc=0, id_instr=NOP_INSTR.
  - buf_valid=0.
- After reset deasserts, imem_req=1 in the first cycle.
- ID consumption: a cycle with id_valid=1 and stall=0 consumes ID.
- IF/ID is free for a new instruction when id_valid=0 or ID is consumed that cycle.
- Request rule: once imem_req=1, imem_req and imem_addr stay stable until imem_ack. Only one request is outstanding at a time.
- States:
  - FETCH: imem_req=1, imem_addr=pc.
    - On ack with IF/ID free: id_instr<=rdata, id_pc<=pc, id_valid<=1, pc<=pc+4.
    - On ack with id_valid=1 and stall=1: buf<={rdata,pc}, buf_valid<=1, pc<=pc+4, go to FULL.
    - No ack and ID consumed: id_valid<=0.
  - FULL: imem_req=0; ID and buffer both occupied.
    - On stall=0: ID<=buf (id_valid stays 1), buf_valid<=0, go to FETCH.
  - DRAIN: imem_req=1, imem_addr=latched stale address.
    - On ack: discard rdata, go to FETCH with the new pc.
    - ID and buffer stay empty while in DRAIN.
- Redirect (highest priority, overrides stall and any capture):
  - Next cycle: id_valid=0, buf_valid=0, pc={redirect_pc[63:2],2'b00}.
  - FETCH with ack in the same cycle: data discarded, stay in FETCH; the next request uses the new pc.
  - FETCH without ack: latch the old address and go to DRAIN.
  - DRAIN: update pc, stay in DRAIN.
  - FULL: go to FETCH.
- Latency and throughput:
  - Ack in cycle N gives id_valid=1 in N+1.
  - With zero-wait memory (ack every cycle) and no stall, one instruction per cycle.
- Ordering: instructions reach ID strictly in PC order. None is duplicated or dropped except by redirect.
- pc+4 wraps modulo 2^64 with no error.
- Reset mid-DRAIN or mid-FULL: all state is cleared and the in-flight response is never captured.

Test Plan:
- Reset release, ack every cycle, rdata=0x00500093,0x00A00113,0x00F00193:
  - imem_addr is 0,4,8 on consecutive cycles.
  - id_pc is 0,4,8 starting one cycle after each ack, with id_valid continuous.
- Stall for 3 cycles while ID holds pc 0x4, ack continuous:
  - pc 0x8 goes into the buffer and imem_req drops.
  - On release, id_pc=0x8 next cycle, then imem_addr=0xC.
- Redirect to 0x100 in the same cycle as the ack for 0x10:
  - Next cycle id_valid=0 and imem_addr=0x100.
  - id_pc=0x10 never appears.
- Redirect to 0x203 while the ack for 0x8 is delayed 3 cycles:
  - imem_addr holds 0x8 until the ack and that data is discarded.
  - The next request is 0x200.
- Redirect with stall=1 in FULL: id_valid=0 and buf_valid=0 next cycle, then a request to the target.
- Assert reset during DRAIN between clock edges: outputs return to reset values immediately, and the following ack is ignored.
